// File: rtl/result_window_pkg.sv
// rtl/result_window_pkg.sv - shared types and constants for result_window_acc
package result_window_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_WINDOW    = 4;

  // Counter must hold the value WINDOW itself, not just WINDOW-1.
  function automatic int cnt_width(input int window);
    return $clog2(window + 1);
  endfunction

endpackage

// File: rtl/result_acc_add.sv
// rtl/result_acc_add.sv - accumulator adder with carry-out; saturates when RESULT_WINDOW_ACC_SAT_EN is defined
module result_acc_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0] full;

  assign full  = {1'b0, a} + {1'b0, b};
  assign carry = full[W];

`ifdef RESULT_WINDOW_ACC_SAT_EN
  // An all-ones operand plus anything either stays all-ones or carries, so saturation is sticky.
  assign sum = carry ? {W{1'b1}} : full[W-1:0];
`else
  assign sum = full[W-1:0];
`endif

endmodule

// File: rtl/result_window_acc.sv
// rtl/result_window_acc.sv - windowed sum/max accumulator of x/z; optional saturation via RESULT_WINDOW_ACC_SAT_EN
module result_window_acc
  import result_window_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int WINDOW    = DEF_WINDOW,
  parameter int CNTW      = cnt_width(WINDOW)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*DATAWIDTH-1:0] x,
  input  logic [DATAWIDTH-1:0]   z,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*DATAWIDTH-1:0] sum,
  output logic [DATAWIDTH-1:0]   zmax,
  output logic [CNTW-1:0]        count,
  output logic                   ovf
);

  localparam logic [CNTW-1:0] WIN_CNT = CNTW'(WINDOW);

  state_t state, state_nx;

  logic [2*DATAWIDTH-1:0] acc_sum, add_sum, post_sum;
  logic [DATAWIDTH-1:0]   acc_max, post_max;
  logic [CNTW-1:0]        acc_cnt, post_cnt;
  logic                   acc_ovf, post_ovf, add_carry;
  logic                   accept, close;

  result_acc_add #(.W(2*DATAWIDTH)) u_add (
    .a     (acc_sum),
    .b     (x),
    .sum   (add_sum),
    .carry (add_carry)
  );

  assign in_ready  = (state == ACC) & rst;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;

  // Post-accept view of the accumulators: what a close in this cycle must capture.
  assign post_sum = accept ? add_sum : acc_sum;
  assign post_ovf = acc_ovf | (accept & add_carry);
  assign post_max = (accept && (z > acc_max)) ? z : acc_max;
  assign post_cnt = acc_cnt + {{(CNTW-1){1'b0}}, accept};

  assign close = (state == ACC) &&
                 ((accept && (post_cnt == WIN_CNT)) || (flush && (post_cnt != '0)));

  always_comb begin
    state_nx = state;
    case (state)
      ACC:  if (close)     state_nx = HOLD;
      HOLD: if (out_ready) state_nx = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ACC;
      acc_sum <= '0;
      acc_max <= '0;
      acc_cnt <= '0;
      acc_ovf <= 1'b0;
      sum     <= '0;
      zmax    <= '0;
      count   <= '0;
      ovf     <= 1'b0;
    end else begin
      state <= state_nx;
      if (close) begin
        sum     <= post_sum;
        zmax    <= post_max;
        count   <= post_cnt;
        ovf     <= post_ovf;
        acc_sum <= '0;
        acc_max <= '0;
        acc_cnt <= '0;
        acc_ovf <= 1'b0;
      end else if (accept) begin
        acc_sum <= post_sum;
        acc_max <= post_max;
        acc_cnt <= post_cnt;
        acc_ovf <= post_ovf;
      end
    end
  end

endmodule

// File: tb/tb_result_window_acc.sv
// tb/tb_result_window_acc.sv - scoreboard bench for result_window_acc against a sample-list reference model
module tb_result_window_acc;

  localparam int DW  = 8;
  localparam int WIN = 4;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   x = '0;
  logic [7:0]    z = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [15:0]   sum;
  logic [7:0]    zmax;
  logic [CW-1:0] count;
  logic          ovf;

  result_window_acc #(.DATAWIDTH(DW), .WINDOW(WIN), .CNTW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .z(z),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .zmax(zmax), .count(count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sum;
    int zmax;
    int count;
    int ovf;
  } rec_t;

  rec_t exp_q[$];
  int   win_x[$];
  int   win_z[$];
  bit   hold = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   records = 0;
  int   closes = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rec_t make_rec();
    rec_t r;
    longint total = 0;
    int mx = 0;
    foreach (win_x[i]) total += win_x[i];
    foreach (win_z[i]) if (win_z[i] > mx) mx = win_z[i];
    r.ovf   = (total > 65535) ? 1 : 0;
`ifdef RESULT_WINDOW_ACC_SAT_EN
    r.sum   = (total > 65535) ? 65535 : int'(total);
`else
    r.sum   = int'(total % 65536);
`endif
    r.zmax  = mx;
    r.count = win_x.size();
    return r;
  endfunction

  // Reference: a window is just the list of samples taken since the last close.
  task automatic model_edge(input bit v, input int xv, input int zv, input bit f, input bit ordy, input bit r);
    if (!r) begin
      win_x.delete();
      win_z.delete();
      exp_q.delete();
      hold = 1'b0;
    end else if (hold) begin
      if (ordy) hold = 1'b0;
    end else begin
      if (v) begin
        win_x.push_back(xv);
        win_z.push_back(zv);
      end
      if (win_x.size() == WIN || (f && win_x.size() > 0)) begin
        exp_q.push_back(make_rec());
        closes++;
        win_x.delete();
        win_z.delete();
        hold = 1'b1;
      end
    end
  endtask

  task automatic step(input bit v, input int xv, input int zv, input bit f, input bit ordy, input bit r);
    in_valid = v; x = xv[15:0]; z = zv[7:0]; flush = f; out_ready = ordy; rst = r;
    @(negedge clk);
    chk("in_ready", in_ready, (!hold && r) ? 1 : 0);
    chk("out_valid", out_valid, hold ? 1 : 0);
    @(posedge clk);
    model_edge(v, xv, zv, f, ordy, r);
    #1;
    if (!r) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_zmax", zmax, 0);
      chk("rst_count", count, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_in_ready", in_ready, 0);
    end
  endtask

  // Monitor: every cycle a record is presented it must equal the oldest expected one.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_record", 1, 0);
      end else begin
        chk("sum", sum, exp_q[0].sum);
        chk("zmax", zmax, exp_q[0].zmax);
        chk("count", count, exp_q[0].count);
        chk("ovf", ovf, exp_q[0].ovf);
        if (out_ready) begin
          void'(exp_q.pop_front());
          records++;
        end
      end
    end
  end

  initial begin
    int xs[4];
    int zs[4];
    xs = '{100, 200, 300, 400};
    zs = '{5, 9, 3, 7};
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Basic window with out_ready held high
    for (int i = 0; i < 4; i++) step(1, xs[i], zs[i], 0, 1, 1);
    step(1, 0, 0, 0, 1, 1);

    // Backpressure: in_valid held high while the record is stalled
    for (int i = 0; i < 4; i++) step(1, 1000 + i, 10 + i, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 7, 200, 1, 0, 1);
    step(1, 7, 200, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(1, 2, 1, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);

    // Overflow
    for (int i = 0; i < 4; i++) step(1, 16'hF000, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);

    // Flush alone with empty window, then early flush with a sample
    step(0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 1, 1, 1);
    step(1, 10, 4, 0, 1, 1);
    step(1, 20, 2, 0, 1, 1);
    step(1, 30, 8, 1, 1, 1);
    step(0, 0, 0, 0, 1, 1);

    // Reset mid-window
    step(1, 50, 50, 0, 1, 1);
    step(1, 60, 60, 0, 1, 1);
    step(1, 70, 70, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);

    // Reset while holding a record
    for (int i = 0; i < 4; i++) step(1, 3, 3, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int xv;
      xv = ($urandom % 4 == 0) ? int'($urandom_range(16'hC000, 16'hFFFF)) : int'($urandom % 2000);
      step(($urandom % 4) != 0, xv, int'($urandom % 256), ($urandom % 8) == 0,
           ($urandom % 3) != 0, ($urandom % 80) != 0);
    end

    for (int n = 0; n < 3; n++) step(0, 0, 0, 0, 1, 1);
    chk("pending_records", exp_q.size(), 0);
    chk("records_seen_nonzero", (records > 10) ? 1 : 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
